// File: rtl/volume_sequencer_pkg.sv
// Shared audio package: sequencer state encoding, level width and the
// default level limits reused by the amplitude datapath and display logic.
package volume_sequencer_pkg;

  localparam int unsigned VOL_WIDTH         = 4;
  localparam int unsigned VOL_MAX_LEVEL     = 15;
  localparam int unsigned VOL_DEFAULT_LEVEL = 4;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRampDown = 2'd1,
    StMuted    = 2'd2,
    StRampUp   = 2'd3
  } seq_state_e;

  // One level step from cur toward tgt; holds when already equal.
  function automatic logic [VOL_WIDTH-1:0] step_toward(input logic [VOL_WIDTH-1:0] cur,
                                                      input logic [VOL_WIDTH-1:0] tgt);
    logic [VOL_WIDTH-1:0] res;
    if (cur < tgt) begin
      res = cur + VOL_WIDTH'(1);
    end else if (cur > tgt) begin
      res = cur - VOL_WIDTH'(1);
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/volume_sequencer_ramp_prescaler.sv
// Ramp prescaler: free-running counter 0..RAMP_DIV-1 with synchronous clear.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   clear - synchronous clear back to 0 (wins over counting)
//   tick  - high while the count equals RAMP_DIV-1
module volume_sequencer_ramp_prescaler #(
  parameter int unsigned RAMP_DIV = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = $clog2(RAMP_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(RAMP_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntLast);
    cnt_d = cnt_q + CntW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/volume_sequencer.sv
// Volume sequencer: keeps the user's target level from up/down pulses and
// ramps the applied amplitude one step per prescaler tick on mute/unmute.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   vol_up/vol_down  - one-cycle pulses adjusting the target level
//   mute_toggle      - one-cycle pulse, mute or unmute
//   volume_amplitude - applied level (registered)
//   audio_en         - 0 only while fully muted (registered)
//   muted, busy      - status flags (registered)
//   at_max, at_min   - target at its upper / lower bound
module volume_sequencer
  import volume_sequencer_pkg::*;
#(
  parameter int unsigned VOL_MAX     = VOL_MAX_LEVEL,
  parameter int unsigned VOL_DEFAULT = VOL_DEFAULT_LEVEL,
  parameter int unsigned RAMP_DIV    = 2500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vol_up,
  input  logic                 vol_down,
  input  logic                 mute_toggle,
  output logic [VOL_WIDTH-1:0] volume_amplitude,
  output logic                 audio_en,
  output logic                 muted,
  output logic                 busy,
  output logic                 at_max,
  output logic                 at_min
);

  // One spare bit so saturation is detected before wrap-around.
  localparam int unsigned WideW = VOL_WIDTH + 1;
  localparam logic [WideW-1:0]     VolMaxWide = WideW'(VOL_MAX);
  localparam logic [VOL_WIDTH-1:0] VolMaxL    = VOL_WIDTH'(VOL_MAX);
  localparam logic [VOL_WIDTH-1:0] VolDefL    = VOL_WIDTH'(VOL_DEFAULT);

  seq_state_e           state_q, state_d;
  logic [VOL_WIDTH-1:0] target_q, target_d;
  logic [VOL_WIDTH-1:0] current_q, current_d;
  logic                 audio_en_q, muted_q, busy_q;
  logic [WideW-1:0]     tgt_inc, tgt_dec;
  logic                 tick, presc_clear;

  // Prescaler only runs inside ramp states; a toggle restarts the interval.
  assign presc_clear = mute_toggle || !((state_q == StRampDown) || (state_q == StRampUp));

  volume_sequencer_ramp_prescaler #(
    .RAMP_DIV (RAMP_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .tick  (tick)
  );

  // Target register: saturating up/down, simultaneous pulses cancel.
  always_comb begin
    tgt_inc  = {1'b0, target_q} + WideW'(1);
    tgt_dec  = {1'b0, target_q} - WideW'(1);
    target_d = target_q;
    if (vol_up && !vol_down && (tgt_inc <= VolMaxWide)) begin
      target_d = tgt_inc[VOL_WIDTH-1:0];
    end else if (vol_down && !vol_up && !tgt_dec[VOL_WIDTH]) begin
      target_d = tgt_dec[VOL_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    current_d = current_q;
    unique case (state_q)
      StIdle: begin
        if (mute_toggle) begin
          state_d = (current_q == '0) ? StMuted : StRampDown;
        end else begin
          current_d = target_d;
        end
      end
      StRampDown: begin
        // Toggle wins over a coinciding tick: no step that cycle.
        if (mute_toggle) begin
          state_d = StRampUp;
        end else if (tick) begin
          current_d = current_q - VOL_WIDTH'(1);
          if (current_d == '0) begin
            state_d = StMuted;
          end
        end
      end
      StMuted: begin
        current_d = '0;
        if (mute_toggle) begin
          state_d = StRampUp;
        end else if (target_d == '0) begin
          state_d = StIdle;
        end
      end
      StRampUp: begin
        if (mute_toggle) begin
          // Level 0 has nothing to ramp down; never let it wrap.
          state_d = (current_q == '0) ? StMuted : StRampDown;
        end else if (current_q == target_d) begin
          state_d = StIdle;
        end else if (tick) begin
          current_d = step_toward(current_q, target_d);
          if (current_d == target_d) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      target_q   <= VolDefL;
      current_q  <= VolDefL;
      audio_en_q <= 1'b1;
      muted_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      current_q  <= current_d;
      audio_en_q <= (state_d != StMuted);
      muted_q    <= (state_d == StMuted) || (state_d == StRampDown);
      busy_q     <= (state_d == StRampDown) || (state_d == StRampUp);
    end
  end

  assign volume_amplitude = current_q;
  assign audio_en         = audio_en_q;
  assign muted            = muted_q;
  assign busy             = busy_q;
  assign at_max           = (target_q == VolMaxL);
  assign at_min           = (target_q == '0);

endmodule

// File: tb/tb_volume_sequencer.sv
module tb_volume_sequencer;

  localparam int RD   = 4;
  localparam int VMAX = 15;
  localparam int VDEF = 4;

  // Reference model modes
  localparam int MIdle  = 0;
  localparam int MDown  = 1;
  localparam int MMuted = 2;
  localparam int MUp    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vol_up = 1'b0;
  logic       vol_down = 1'b0;
  logic       mute_toggle = 1'b0;
  logic [3:0] volume_amplitude;
  logic       audio_en, muted, busy, at_max, at_min;

  int errors = 0;
  int checks = 0;

  int m_target, m_level, m_wait, m_mode;

  volume_sequencer #(
    .VOL_MAX     (VMAX),
    .VOL_DEFAULT (VDEF),
    .RAMP_DIV    (RD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .vol_up           (vol_up),
    .vol_down         (vol_down),
    .mute_toggle      (mute_toggle),
    .volume_amplitude (volume_amplitude),
    .audio_en         (audio_en),
    .muted            (muted),
    .busy             (busy),
    .at_max           (at_max),
    .at_min           (at_min)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_target = VDEF;
    m_level  = VDEF;
    m_wait   = RD;
    m_mode   = MIdle;
  endfunction

  // Behavioural model: m_wait counts cycles left until the next level step.
  function automatic void model_step(input bit up, input bit dn, input bit tg);
    int nt;
    nt = m_target;
    if (up && !dn) nt = (m_target < VMAX) ? m_target + 1 : VMAX;
    if (dn && !up) nt = (m_target > 0) ? m_target - 1 : 0;
    case (m_mode)
      MIdle: begin
        if (tg) begin
          m_wait = RD;
          m_mode = (m_level == 0) ? MMuted : MDown;
        end else begin
          m_level = nt;
        end
      end
      MDown: begin
        if (tg) begin
          m_wait = RD;
          m_mode = MUp;
        end else begin
          m_wait--;
          if (m_wait == 0) begin
            m_wait = RD;
            m_level--;
            if (m_level == 0) m_mode = MMuted;
          end
        end
      end
      MMuted: begin
        m_level = 0;
        if (tg) begin
          m_wait = RD;
          m_mode = MUp;
        end else if (nt == 0) begin
          m_mode = MIdle;
        end
      end
      default: begin
        if (tg) begin
          m_wait = RD;
          m_mode = (m_level == 0) ? MMuted : MDown;
        end else if (m_level == nt) begin
          m_mode = MIdle;
        end else begin
          m_wait--;
          if (m_wait == 0) begin
            m_wait = RD;
            m_level += (nt > m_level) ? 1 : -1;
            if (m_level == nt) m_mode = MIdle;
          end
        end
      end
    endcase
    m_target = nt;
  endfunction

  // Drives one cycle of pulses; returns #1 after the edge for sampling.
  task automatic pulse(input bit up, input bit dn, input bit tg);
    vol_up = up;
    vol_down = dn;
    mute_toggle = tg;
    @(posedge clk);
    model_step(up, dn, tg);
    #1;
    vol_up = 1'b0;
    vol_down = 1'b0;
    mute_toggle = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (volume_amplitude !== 4'd4) begin
      errors++;
      $display("FAIL reset_level: got %0d expected 4", volume_amplitude);
    end
    checks++;
    if ({audio_en, muted, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got en/muted/busy=%b expected 100", {audio_en, muted, busy});
    end
    checks++;
    if ({at_max, at_min} !== 2'b00) begin
      errors++;
      $display("FAIL reset_bounds: got max/min=%b expected 00", {at_max, at_min});
    end
  endtask

  task automatic test_idle_up();
    for (int i = 0; i < 3; i++) pulse(1, 0, 0);
    checks++;
    if (volume_amplitude !== 4'd7) begin
      errors++;
      $display("FAIL idle_up: got %0d expected 7", volume_amplitude);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) pulse(1, 0, 0);
    checks++;
    if (volume_amplitude !== 4'd15 || at_max !== 1'b1) begin
      errors++;
      $display("FAIL sat_max: got level=%0d at_max=%b expected 15 1", volume_amplitude, at_max);
    end
    for (int i = 0; i < 20; i++) pulse(0, 1, 0);
    checks++;
    if (volume_amplitude !== 4'd0 || at_min !== 1'b1 || audio_en !== 1'b1) begin
      errors++;
      $display("FAIL sat_min: got level=%0d at_min=%b en=%b expected 0 1 1",
               volume_amplitude, at_min, audio_en);
    end
    for (int i = 0; i < 7; i++) pulse(1, 0, 0);
    pulse(1, 1, 0);
    pulse(0, 0, 0);
    checks++;
    if (volume_amplitude !== 4'd7) begin
      errors++;
      $display("FAIL up_down_cancel: got %0d expected 7", volume_amplitude);
    end
  endtask

  task automatic test_mute_ramp();
    int exp_lvl;
    do_reset();
    pulse(0, 0, 1);
    checks++;
    if (muted !== 1'b1 || busy !== 1'b1 || volume_amplitude !== 4'd4) begin
      errors++;
      $display("FAIL mute_entry: got muted=%b busy=%b level=%0d expected 1 1 4",
               muted, busy, volume_amplitude);
    end
    for (int j = 1; j <= 16; j++) begin
      pulse(0, 0, 0);
      exp_lvl = 4 - j / RD;
      checks++;
      if (volume_amplitude !== 4'(exp_lvl) || audio_en !== (j < 16)) begin
        errors++;
        $display("FAIL mute_ramp cycle %0d: got level=%0d en=%b expected %0d %b",
                 j, volume_amplitude, audio_en, exp_lvl, (j < 16));
      end
    end
    checks++;
    if (busy !== 1'b0 || muted !== 1'b1) begin
      errors++;
      $display("FAIL mute_done: got busy=%b muted=%b expected 0 1", busy, muted);
    end
  endtask

  task automatic test_unmute_edit();
    int exp_lvl;
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    checks++;
    if (volume_amplitude !== 4'd0 || audio_en !== 1'b0) begin
      errors++;
      $display("FAIL muted_edit: got level=%0d en=%b expected 0 0", volume_amplitude, audio_en);
    end
    pulse(0, 0, 1);
    for (int j = 1; j <= 24; j++) begin
      pulse(0, 0, 0);
      exp_lvl = j / RD;
      checks++;
      if (volume_amplitude !== 4'(exp_lvl) || audio_en !== 1'b1 || busy !== (j < 24)) begin
        errors++;
        $display("FAIL unmute_ramp cycle %0d: got level=%0d en=%b busy=%b expected %0d 1 %b",
                 j, volume_amplitude, audio_en, busy, exp_lvl, (j < 24));
      end
    end
    checks++;
    if (muted !== 1'b0) begin
      errors++;
      $display("FAIL unmute_done: got muted=%b expected 0", muted);
    end
  endtask

  task automatic test_reversal();
    int exp_lvl;
    do_reset();
    pulse(0, 0, 1);
    for (int j = 0; j < 8; j++) pulse(0, 0, 0);
    checks++;
    if (volume_amplitude !== 4'd2) begin
      errors++;
      $display("FAIL reversal_pre: got %0d expected 2", volume_amplitude);
    end
    pulse(0, 0, 1);
    for (int j = 1; j <= 8; j++) begin
      pulse(0, 0, 0);
      exp_lvl = 2 + j / RD;
      checks++;
      if (volume_amplitude !== 4'(exp_lvl) || muted !== 1'b0) begin
        errors++;
        $display("FAIL reversal cycle %0d: got level=%0d muted=%b expected %0d 0",
                 j, volume_amplitude, muted, exp_lvl);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reversal_done: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_ramp();
    pulse(0, 0, 1);
    for (int j = 0; j < 4; j++) pulse(0, 0, 0);
    pulse(0, 0, 1);
    pulse(0, 0, 0);
    checks++;
    if (busy !== 1'b1 || muted !== 1'b0 || volume_amplitude !== 4'd3) begin
      errors++;
      $display("FAIL ramp_up_pre: got busy=%b muted=%b level=%0d expected 1 0 3",
               busy, muted, volume_amplitude);
    end
    do_reset();
    checks++;
    if (volume_amplitude !== 4'd4 || {audio_en, muted, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid_ramp: got level=%0d en/muted/busy=%b expected 4 100",
               volume_amplitude, {audio_en, muted, busy});
    end
  endtask

  task automatic test_random();
    int r;
    bit up, dn, tg;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 99));
      up = (r < 12) || (r >= 24 && r < 27);
      dn = (r >= 12 && r < 27);
      tg = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else pulse(up, dn, tg);
      checks++;
      if (volume_amplitude !== 4'(m_level)) begin
        errors++;
        $display("FAIL rand_level @%0d: got %0d expected %0d", i, volume_amplitude, m_level);
      end
      checks++;
      if (audio_en !== (m_mode != MMuted)) begin
        errors++;
        $display("FAIL rand_audio_en @%0d: got %b expected %b", i, audio_en, (m_mode != MMuted));
      end
      checks++;
      if (muted !== (m_mode == MMuted || m_mode == MDown)) begin
        errors++;
        $display("FAIL rand_muted @%0d: got %b expected %b", i, muted,
                 (m_mode == MMuted || m_mode == MDown));
      end
      checks++;
      if (busy !== (m_mode == MDown || m_mode == MUp)) begin
        errors++;
        $display("FAIL rand_busy @%0d: got %b expected %b", i, busy,
                 (m_mode == MDown || m_mode == MUp));
      end
      checks++;
      if (at_max !== (m_target == VMAX) || at_min !== (m_target == 0)) begin
        errors++;
        $display("FAIL rand_bounds @%0d: got max/min=%b%b target %0d", i, at_max, at_min,
                 m_target);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_up();
    test_saturation();
    test_mute_ramp();
    test_unmute_edit();
    test_reversal();
    test_reset_mid_ramp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
